// File: rtl/fill_cycle_monitor.sv
// Purpose: watches the tank full indication for period, stuck-high and first-event liveness faults.
// Latency: every output is registered; gap/count/flags update on the edge that samples a rise, fault one cycle later.
// Backpressure: none; the input is sampled every cycle and the outputs are plain status levels.
module fill_cycle_monitor #(
    parameter int CBITS         = 16,
    parameter int ECNT_W        = 8,
    parameter int MIN_GAP       = 29990,
    parameter int MAX_GAP       = 30010,
    parameter int FIRST_TIMEOUT = 16000,
    parameter int MAX_HIGH      = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              full_in,
    output logic              evt_pulse,
    output logic [CBITS-1:0]  gap,
    output logic [ECNT_W-1:0] evt_count,
    output logic              in_window,
    output logic              early_err,
    output logic              late_err,
    output logic              stuck_err,
    output logic              fault
);

    // high_cnt only has to reach MAX_HIGH + 1
    localparam int HW = $clog2(MAX_HIGH + 2);

    localparam logic [CBITS-1:0]  MIN_G     = CBITS'(MIN_GAP);
    localparam logic [CBITS-1:0]  MAX_G     = CBITS'(MAX_GAP);
    localparam logic [CBITS-1:0]  FIRST_TO  = CBITS'(FIRST_TIMEOUT);
    localparam logic [CBITS-1:0]  GAP_SAT   = {CBITS{1'b1}};
    localparam logic [ECNT_W-1:0] EVT_SAT   = {ECNT_W{1'b1}};
    localparam logic [HW-1:0]     HIGH_LIM  = HW'(MAX_HIGH);
    localparam logic [HW-1:0]     HIGH_SAT  = HW'(MAX_HIGH + 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        TRACK = 2'd1,
        FAULT = 2'd2
    } state_t;

    state_t            state;
    state_t            state_nxt;
    logic              prev;
    logic [HW-1:0]     high_cnt;
    logic [CBITS-1:0]  gap_cnt;

    logic rise;
    logic stuck_hit;
    logic gap_early;
    logic gap_ok;
    logic set_early;
    logic set_late;
    logic set_stuck;

    assign rise      = full_in & ~prev;
    // this high sample would be the (MAX_HIGH + 1)-th in a row
    assign stuck_hit = full_in & (high_cnt == HIGH_LIM);
    assign gap_early = (gap_cnt < MIN_G);
    assign gap_ok    = ~gap_early & (gap_cnt <= MAX_G);

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next state and flag-set decisions; a rise always beats the timeout in the same cycle.
    always_comb begin
        state_nxt = state;
        set_early = 1'b0;
        set_late  = 1'b0;
        set_stuck = 1'b0;
        case (state)
            IDLE: begin
                if (rise) begin
                    state_nxt = TRACK;
                end else if (gap_cnt >= FIRST_TO) begin
                    set_late  = 1'b1;
                    state_nxt = FAULT;
                end
            end
            TRACK: begin
                if (rise) begin
                    if (gap_early) begin
                        set_early = 1'b1;
                        state_nxt = FAULT;
                    end
                end else if (gap_cnt == MAX_G) begin
                    set_late  = 1'b1;
                    state_nxt = FAULT;
                end
            end
            FAULT: begin
                state_nxt = FAULT;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
        // Stuck detection is live in every state, including FAULT.
        if (stuck_hit) begin
            set_stuck = 1'b1;
            state_nxt = FAULT;
        end
    end

    // Previous sample and saturating run length of consecutive high samples.
    always_ff @(posedge clk) begin
        if (rst) begin
            prev     <= 1'b0;
            high_cnt <= '0;
        end else begin
            prev <= full_in;
            if (!full_in) begin
                high_cnt <= '0;
            end else if (high_cnt != HIGH_SAT) begin
                high_cnt <= high_cnt + 1'b1;
            end
        end
    end

    // Gap counter restarts at 1 on every rise; otherwise counts up and sticks at all-ones.
    always_ff @(posedge clk) begin
        if (rst) begin
            gap_cnt <= '0;
        end else if (rise) begin
            gap_cnt <= {{(CBITS-1){1'b0}}, 1'b1};
        end else if (gap_cnt != GAP_SAT) begin
            gap_cnt <= gap_cnt + 1'b1;
        end
    end

    // Publish the measured gap and window status; the first rise after reset has no predecessor.
    always_ff @(posedge clk) begin
        if (rst) begin
            gap       <= '0;
            in_window <= 1'b0;
        end else if (rise && (state != IDLE)) begin
            gap       <= gap_cnt;
            in_window <= gap_ok;
        end
    end

    // Event pulse and saturating event count.
    always_ff @(posedge clk) begin
        if (rst) begin
            evt_pulse <= 1'b0;
            evt_count <= '0;
        end else begin
            evt_pulse <= rise;
            if (rise && (evt_count != EVT_SAT)) begin
                evt_count <= evt_count + 1'b1;
            end
        end
    end

    // Sticky error flags; only reset clears them.
    always_ff @(posedge clk) begin
        if (rst) begin
            early_err <= 1'b0;
            late_err  <= 1'b0;
            stuck_err <= 1'b0;
        end else begin
            early_err <= early_err | set_early;
            late_err  <= late_err  | set_late;
            stuck_err <= stuck_err | set_stuck;
        end
    end

    // Summary fault, one cycle behind the individual flags.
    always_ff @(posedge clk) begin
        if (rst) begin
            fault <= 1'b0;
        end else begin
            fault <= early_err | late_err | stuck_err;
        end
    end

endmodule

// File: tb/tb_fill_cycle_monitor.sv
// Purpose: directed self-checking bench for fill_cycle_monitor with a small window configuration.
// Latency: inputs change 1 time unit after a rising edge, outputs are checked at the same point.
// Backpressure: not applicable.
module tb_fill_cycle_monitor;

    localparam int CBITS  = 16;
    localparam int ECNT_W = 8;

    logic              clk;
    logic              rst;
    logic              full_in;
    logic              evt_pulse;
    logic [CBITS-1:0]  gap;
    logic [ECNT_W-1:0] evt_count;
    logic              in_window;
    logic              early_err;
    logic              late_err;
    logic              stuck_err;
    logic              fault;

    int checks = 0;
    int errors = 0;

    fill_cycle_monitor #(
        .CBITS         (CBITS),
        .ECNT_W        (ECNT_W),
        .MIN_GAP       (8),
        .MAX_GAP       (12),
        .FIRST_TIMEOUT (20),
        .MAX_HIGH      (2)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .full_in   (full_in),
        .evt_pulse (evt_pulse),
        .gap       (gap),
        .evt_count (evt_count),
        .in_window (in_window),
        .early_err (early_err),
        .late_err  (late_err),
        .stuck_err (stuck_err),
        .fault     (fault)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One clock edge sampling the given full_in value.
    task automatic step(input logic f);
        full_in = f;
        tick();
    endtask

    task automatic pulse(input int highs, input int lows);
        for (int i = 0; i < highs; i++) step(1'b1);
        for (int i = 0; i < lows; i++) step(1'b0);
    endtask

    task automatic do_reset();
        rst     = 1'b1;
        full_in = 1'b0;
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_pulse"}, {31'd0, evt_pulse}, 32'd0);
        check({tag, "_gap"},   {16'd0, gap},       32'd0);
        check({tag, "_cnt"},   {24'd0, evt_count}, 32'd0);
        check({tag, "_win"},   {31'd0, in_window}, 32'd0);
        check({tag, "_early"}, {31'd0, early_err}, 32'd0);
        check({tag, "_late"},  {31'd0, late_err},  32'd0);
        check({tag, "_stuck"}, {31'd0, stuck_err}, 32'd0);
        check({tag, "_fault"}, {31'd0, fault},     32'd0);
    endtask

    initial begin
        rst     = 1'b1;
        full_in = 1'b0;

        // Reset state
        do_reset();
        check_all_zero("reset");

        // 1: 2-high pulses every 10 cycles, rises at edges 1,11,21,31,41
        step(1'b1);
        check("t1_pulse_hi", {31'd0, evt_pulse}, 32'd1);
        check("t1_cnt1", {24'd0, evt_count}, 32'd1);
        check("t1_gap_first", {16'd0, gap}, 32'd0);
        step(1'b1);
        check("t1_pulse_lo", {31'd0, evt_pulse}, 32'd0);
        for (int i = 0; i < 8; i++) step(1'b0);
        for (int p = 0; p < 4; p++) pulse(2, 8);
        check("t1_cnt", {24'd0, evt_count}, 32'd5);
        check("t1_gap", {16'd0, gap}, 32'd10);
        check("t1_win", {31'd0, in_window}, 32'd1);
        check("t1_early", {31'd0, early_err}, 32'd0);
        check("t1_late", {31'd0, late_err}, 32'd0);
        check("t1_stuck", {31'd0, stuck_err}, 32'd0);
        check("t1_fault", {31'd0, fault}, 32'd0);

        // 2: rise at edge 5, next at edge 11 (gap 6)
        do_reset();
        for (int i = 0; i < 4; i++) step(1'b0);
        pulse(2, 4);
        step(1'b1);
        check("t2_early", {31'd0, early_err}, 32'd1);
        check("t2_fault_lag", {31'd0, fault}, 32'd0);
        check("t2_gap", {16'd0, gap}, 32'd6);
        check("t2_win", {31'd0, in_window}, 32'd0);
        step(1'b1);
        check("t2_fault", {31'd0, fault}, 32'd1);
        step(1'b0);

        // 3a: rise at edge 1 then held low; late_err after edge 13
        do_reset();
        pulse(2, 10);
        check("t3_late_e12", {31'd0, late_err}, 32'd0);
        step(1'b0);
        check("t3_late_e13", {31'd0, late_err}, 32'd1);
        step(1'b0);
        check("t3_fault", {31'd0, fault}, 32'd1);

        // 3b: second rise exactly 12 cycles after the first is legal
        do_reset();
        pulse(2, 10);
        step(1'b1);
        check("t3b_late", {31'd0, late_err}, 32'd0);
        check("t3b_gap", {16'd0, gap}, 32'd12);
        check("t3b_win", {31'd0, in_window}, 32'd1);
        step(1'b0);
        check("t3b_late_after", {31'd0, late_err}, 32'd0);

        // 4: no edge after reset; late_err visible after edge 21
        do_reset();
        for (int i = 0; i < 20; i++) step(1'b0);
        check("t4_late_e20", {31'd0, late_err}, 32'd0);
        step(1'b0);
        check("t4_late_e21", {31'd0, late_err}, 32'd1);
        for (int i = 0; i < 4; i++) step(1'b0);
        check("t4_cnt", {24'd0, evt_count}, 32'd0);
        check("t4_fault", {31'd0, fault}, 32'd1);

        // 5: two highs are fine, three highs are stuck
        do_reset();
        pulse(2, 1);
        check("t5_two_high", {31'd0, stuck_err}, 32'd0);
        do_reset();
        pulse(2, 0);
        check("t5_after2", {31'd0, stuck_err}, 32'd0);
        step(1'b1);
        check("t5_after3", {31'd0, stuck_err}, 32'd1);
        step(1'b0);
        check("t5_fault", {31'd0, fault}, 32'd1);

        // 6: early fault at edge 6, then gap-10 pulses; last pulse runs past MAX_GAP
        do_reset();
        pulse(2, 3);
        pulse(2, 8);
        check("t6_early", {31'd0, early_err}, 32'd1);
        pulse(2, 8);
        pulse(2, 8);
        pulse(2, 15);
        check("t6_cnt", {24'd0, evt_count}, 32'd5);
        check("t6_gap", {16'd0, gap}, 32'd10);
        check("t6_win", {31'd0, in_window}, 32'd1);
        check("t6_early_hold", {31'd0, early_err}, 32'd1);
        check("t6_no_late", {31'd0, late_err}, 32'd0);
        check("t6_fault", {31'd0, fault}, 32'd1);
        rst = 1'b1;
        step(1'b0);
        rst = 1'b0;
        check_all_zero("t6_rst");
        // Back in IDLE: first-event timeout applies again
        for (int i = 0; i < 20; i++) step(1'b0);
        check("t6_idle_e20", {31'd0, late_err}, 32'd0);
        step(1'b0);
        check("t6_idle_e21", {31'd0, late_err}, 32'd1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
